// File: rtl/dcache_controller_pkg.sv
// rtl/dcache_controller_pkg.sv - shared state encoding and address-field widths
// for the data-cache sequencing FSM.
package dcache_controller_pkg;

  // Byte offset within a 4-word line: addr[3:2] word, addr[1:0] byte.
  localparam int OFFSET_BITS   = 4;
  localparam int WORD_SEL_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_WRITE_MEM = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_controller_tag_store.sv
// rtl/dcache_controller_tag_store.sv - per-line tag and valid registers with a
// combinational read port and a single write port.
module dcache_controller_tag_store #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic                  rd_valid_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic                  set_valid_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0] tag_q   [LINES];
  logic                valid_q [LINES];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (we_i) begin
      tag_q[wr_index_i]   <= wr_tag_i;
      valid_q[wr_index_i] <= set_valid_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through no-write-allocate data
// cache sequencer: tag compare, 4-word refill, store forwarding, core stall.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int INDEX_BITS = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  output logic                     stall,
  output logic                     hit,
  output logic                     cache_we,
  output logic [INDEX_BITS-1:0]    cache_index,
  output logic [WORD_SEL_BITS-1:0] cache_word_sel,
  output logic                     cache_src_sel,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_ready
);

  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WADDR_BITS = ADDR_WIDTH - 2;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [WADDR_BITS-1:0]   waddr_q, waddr_d;
  logic                    hit_q, hit_d;

  logic [TAG_BITS-1:0]     cpu_tag, lat_tag, rd_tag;
  logic [INDEX_BITS-1:0]   cpu_index, lat_index;
  logic [1:0]              cpu_off, lat_off;
  logic                    rd_valid, lookup_hit, tag_we;
  logic                    addr_unused;

  assign cpu_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign cpu_index   = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign cpu_off     = cpu_addr[3:2];
  assign addr_unused = ^cpu_addr[1:0];

  // The latched word address serves both refill (tag/index) and store (full word).
  assign lat_tag   = waddr_q[WADDR_BITS-1 -: TAG_BITS];
  assign lat_index = waddr_q[2 +: INDEX_BITS];
  assign lat_off   = waddr_q[1:0];

  dcache_controller_tag_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tag_store (
    .CLK         (CLK),
    .RST         (RST),
    .rd_index_i  (cpu_index),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .we_i        (tag_we),
    .wr_index_i  (lat_index),
    .wr_tag_i    (lat_tag),
    .set_valid_i (1'b1)
  );

  assign lookup_hit = rd_valid & (rd_tag == cpu_tag);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      waddr_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    waddr_d        = waddr_q;
    hit_d          = hit_q;
    tag_we         = 1'b0;
    stall          = 1'b0;
    hit            = 1'b0;
    cache_we       = 1'b0;
    cache_index    = '0;
    cache_word_sel = '0;
    cache_src_sel  = 1'b0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    mem_addr       = '0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write is handled as a write.
        if (cpu_mem_write) begin
          hit            = lookup_hit;
          stall          = 1'b1;
          cache_index    = cpu_index;
          cache_word_sel = cpu_off;
          waddr_d        = cpu_addr[ADDR_WIDTH-1:2];
          hit_d          = lookup_hit;
          state_d        = ST_WRITE_MEM;
        end else if (cpu_mem_read) begin
          hit            = lookup_hit;
          cache_index    = cpu_index;
          cache_word_sel = cpu_off;
          if (!lookup_hit) begin
            stall   = 1'b1;
            waddr_d = cpu_addr[ADDR_WIDTH-1:2];
            cnt_d   = 2'd0;
            state_d = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        stall          = 1'b1;
        mem_rd_req     = 1'b1;
        mem_addr       = {waddr_q[WADDR_BITS-1:2], cnt_q, 2'b00};
        cache_index    = lat_index;
        cache_word_sel = cnt_q;
        cache_src_sel  = 1'b1;
        if (mem_ready) begin
          cache_we = 1'b1;
          cnt_d    = cnt_q + 2'd1;
          // Tag and valid are only committed once the whole line has arrived.
          if (cnt_q == 2'd3) begin
            tag_we  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WRITE_MEM: begin
        mem_wr_req     = 1'b1;
        mem_addr       = {waddr_q, 2'b00};
        stall          = ~mem_ready;
        cache_index    = lat_index;
        cache_word_sel = lat_off;
        if (mem_ready) begin
          cache_we = hit_q;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are quiet while reset is held, even with a request still pending.
    if (RST) begin
      tag_we         = 1'b0;
      stall          = 1'b0;
      hit            = 1'b0;
      cache_we       = 1'b0;
      cache_index    = '0;
      cache_word_sel = '0;
      cache_src_sel  = 1'b0;
      mem_rd_req     = 1'b0;
      mem_wr_req     = 1'b0;
      mem_addr       = '0;
    end
  end

endmodule
